mul_share_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline controller that shares one 24×24 immediate multiplier among several requesters in the 24-bit CPU datapath, such as the execute-stage MUL path, address scaling and the immediate-scaling unit. It accepts operand pairs over valid/ready handshakes and owns the single multiplier instance. It returns the low 24 bits of each product, plus an overflow flag, to the requester that issued it, with full backpressure.

---
 rtl/mul_arb_pkg.sv | 32 +++
 rtl/mul24_core.sv | 13 +
 rtl/mul_share_arb.sv | 119 +++++++++++
 tb/tb_mul_share_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mul_arb_pkg;

   localparam int W_DEF    = 24;
   localparam int NREQ_DEF = 3;
   localparam int NREQ_MAX = 8;

   // Width of a requester index for a given requester count (at least 1 bit).
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDW     = id_width(NREQ_DEF);
   // Stage id fields are sized for the largest legal requester count so the
   // same stage types serve every legal NREQ.
   localparam int IDW_MAX = id_width(NREQ_MAX);

   // Operand stage: issuing requester and its operand pair.
   typedef struct packed {
      logic [IDW_MAX-1:0] id;
      logic [W_DEF-1:0]   a;
      logic [W_DEF-1:0]   b;
   } mul_s1_t;

   // Result stage: issuing requester, truncated product, overflow flag.
   typedef struct packed {
      logic [IDW_MAX-1:0] id;
      logic [W_DEF-1:0]   prod;
      logic               ovf;
   } mul_s2_t;

endpackage

// File: rtl/mul24_core.sv
// Combinational unsigned W x W -> 2W multiplier shared by all requesters.
module mul24_core #(
   parameter int W = 24
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [2*W-1:0] o_p
);

   // Full-width unsigned product; operands widened first so nothing is lost.
   assign o_p = (2*W)'(i_a) * (2*W)'(i_b);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter plus two-stage pipeline around a single shared
// multiplier. S1 holds the granted operands, S2 holds the product until the
// issuing requester accepts it. The stage types carry W_DEF-wide data, so W
// is expected to stay at its default.
module mul_share_arb
   import mul_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [W-1:0]      resp_prod,
   output logic              resp_ovf
);

   localparam int PW = (NREQ == NREQ_DEF) ? IDW : id_width(NREQ);

   mul_s1_t         r_s1;
   mul_s2_t         r_s2;
   logic            r_v1;
   logic            r_v2;
   logic [PW-1:0]   r_ptr;

   logic [NREQ-1:0] w_resp_valid;
   logic            w_pop;
   logic            w_adv1;
   logic            w_adv2;
   logic [NREQ-1:0] w_grant;
   logic            w_gnt_any;
   logic [PW-1:0]   w_gidx;
   logic [PW-1:0]   w_ptr_nxt;
   logic [W-1:0]    w_a;
   logic [W-1:0]    w_b;
   logic [2*W-1:0]  w_prod;

   // First valid requester scanning upward from ptr with wrap-around.
   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                                input logic [PW-1:0]   ptr);
      logic [NREQ-1:0] gnt;
      logic            found;
      int              idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && valid[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

   // Result addressing and handshake: only the issuer's resp_ready matters.
   always_comb begin
      w_resp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_v2 && (int'(r_s2.id) == i)) w_resp_valid[i] = 1'b1;
      end
      w_pop  = |(w_resp_valid & resp_ready);
      w_adv2 = ~r_v2 | w_pop;
      w_adv1 = ~r_v1 | w_adv2;
   end

   // Grant selection and operand mux; grants are suppressed while in reset.
   always_comb begin
      w_grant   = (rst_n && w_adv1) ? rr_grant(req_valid, r_ptr) : '0;
      w_gnt_any = |w_grant;
      w_gidx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) w_gidx = PW'(i);
      end
      w_ptr_nxt = (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
      w_a       = req_a[int'(w_gidx)*W +: W];
      w_b       = req_b[int'(w_gidx)*W +: W];
   end

   mul24_core #(.W(W)) u_mul (
      .i_a (r_s1.a),
      .i_b (r_s1.b),
      .o_p (w_prod)
   );

   // Pipeline stages and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_ptr <= '0;
      end else begin
         if (w_adv2) begin
            r_v2 <= r_v1;
            r_s2 <= '{id: r_s1.id, prod: w_prod[W-1:0], ovf: |w_prod[2*W-1:W]};
         end
         if (w_adv1) begin
            r_v1 <= w_gnt_any;
            if (w_gnt_any) begin
               r_s1  <= '{id: IDW_MAX'(w_gidx), a: w_a, b: w_b};
               r_ptr <= w_ptr_nxt;
            end
         end
      end
   end

   assign req_ready  = w_grant;
   assign resp_valid = w_resp_valid;
   assign resp_prod  = r_s2.prod;
   assign resp_ovf   = r_s2.ovf;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: an in-flight queue model predicts grants and
// results every cycle; directed scenarios add literal expectations.
module tb_mul_share_arb;

   localparam int N = 3;
   localparam int W = 24;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [W-1:0]    resp_prod;
   logic            resp_ovf;

   mul_share_arb #(.NREQ(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_prod  (resp_prod),
      .resp_ovf   (resp_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: ops in issue order with edges elapsed since their transfer.
   // The oldest op is presented once it has aged one edge; at most two
   // ops are in flight, and a new one is accepted if there is room or the
   // head leaves this cycle.
   typedef struct {
      int          id;
      logic [23:0] a;
      logic [23:0] b;
      int          age;
   } op_t;
   op_t         mq[$];
   int          m_ptr = 0;
   logic [N-1:0] m_grant;
   bit          m_pop;

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, return at +1.
   task automatic step();
      logic [N-1:0] exp_rv;
      logic [47:0]  p;
      int           idx;
      @(negedge clk);
      m_grant = '0;
      m_pop   = 1'b0;
      if (!rst_n) begin
         chk("rst_req_ready", 48'(req_ready), 48'd0);
         chk("rst_resp_valid", 48'(resp_valid), 48'd0);
         chk("rst_resp_prod", 48'(resp_prod), 48'd0);
         chk("rst_resp_ovf", 48'(resp_ovf), 48'd0);
      end else begin
         exp_rv = '0;
         if (mq.size() > 0 && mq[0].age >= 1) begin
            exp_rv[mq[0].id] = 1'b1;
            p = 48'(mq[0].a) * 48'(mq[0].b);
            m_pop = resp_ready[mq[0].id];
            chk("model_prod", 48'(resp_prod), 48'(p[23:0]));
            chk("model_ovf", 48'(resp_ovf), 48'(p[47:24] != 0));
         end
         chk("model_resp_valid", 48'(resp_valid), 48'(exp_rv));
         if (mq.size() < 2 || m_pop) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (req_valid[idx] && m_grant == 0) m_grant[idx] = 1'b1;
            end
         end
         chk("model_req_ready", 48'(req_ready), 48'(m_grant));
      end
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_ptr = 0;
      end else begin
         foreach (mq[i]) mq[i].age++;
         if (m_pop) void'(mq.pop_front());
         for (int g = 0; g < N; g++) begin
            if (m_grant[g]) begin
               mq.push_back('{id: g, a: req_a[g*W +: W], b: req_b[g*W +: W], age: 0});
               m_ptr = (g + 1) % N;
            end
         end
      end
      #1;
   endtask

   task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
      req_valid[i]      = 1'b1;
      req_a[i*W +: W]   = a;
      req_b[i*W +: W]   = b;
   endtask

   function automatic logic [23:0] rnd24();
      case ($urandom_range(0, 3))
         0:       return 24'($urandom);
         1:       return 24'($urandom_range(0, 15));
         2:       return 24'hFFFFFF - 24'($urandom_range(0, 15));
         default: return 24'd1 << $urandom_range(0, 23);
      endcase
   endfunction

   task automatic drain();
      req_valid  = '0;
      resp_ready = '1;
      repeat (4) step();
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '1;
      step();
      step();
   endtask

   int rdy_pct;

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = '1;
      #1;
      chk("reset_req_ready", 48'(req_ready), 48'd0);
      chk("reset_resp_valid", 48'(resp_valid), 48'd0);
      chk("reset_resp_prod", 48'(resp_prod), 48'd0);
      do_reset();
      rst_n = 1'b1;
      step();

      // Single op from requester 0.
      set_op(0, 24'd5, 24'd7);
      #1 chk("single_ready", 48'(req_ready), 48'b001);
      step();
      req_valid = '0;
      step();
      chk("single_valid", 48'(resp_valid), 48'b001);
      chk("single_prod", 48'(resp_prod), 48'd35);
      chk("single_ovf", 48'(resp_ovf), 48'd0);
      drain();

      // Contention from reset: grants 0,1,2; results 20,30,40.
      do_reset();
      set_op(0, 24'd2, 24'd10);
      set_op(1, 24'd3, 24'd10);
      set_op(2, 24'd4, 24'd10);
      rst_n = 1'b1;
      for (int k = 0; k < N; k++) begin
         #1 chk("cont_grant", 48'(req_ready), 48'(1 << k));
         step();
         req_valid[k] = 1'b0;
         if (k > 0) begin
            chk("cont_valid", 48'(resp_valid), 48'(1 << (k - 1)));
            chk("cont_prod", 48'(resp_prod), 48'((k + 1) * 10));
         end
      end
      step();
      chk("cont_valid_last", 48'(resp_valid), 48'b100);
      chk("cont_prod_last", 48'(resp_prod), 48'd40);
      req_valid = 3'b101;
      #1 chk("cont_ptr_zero", 48'(req_ready), 48'b001);
      req_valid = '0;
      drain();

      // Fairness: 1 and 2 continuously valid alternate, starting at 1.
      set_op(1, rnd24(), rnd24());
      set_op(2, rnd24(), rnd24());
      for (int k = 0; k < 6; k++) begin
         #1 chk("fair_grant", 48'(req_ready), (k % 2 == 0) ? 48'b010 : 48'b100);
         step();
         for (int i = 1; i < N; i++) if (m_grant[i]) set_op(i, rnd24(), rnd24());
      end
      drain();

      // Backpressure on requester 0.
      resp_ready = 3'b110;
      set_op(0, 24'd1, 24'd11);
      step();
      set_op(0, 24'd2, 24'd11);
      step();
      set_op(0, 24'd3, 24'd11);
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready_low", 48'(req_ready), 48'd0);
         chk("bp_hold_prod", 48'(resp_prod), 48'd11);
         step();
      end
      resp_ready = '1;
      #1 chk("bp_release_grant", 48'(req_ready), 48'b001);
      step();
      req_valid = '0;
      chk("bp_drain2", 48'(resp_prod), 48'd22);
      step();
      chk("bp_drain3", 48'(resp_prod), 48'd33);
      chk("bp_drain3_valid", 48'(resp_valid), 48'b001);
      step();
      chk("bp_empty", 48'(resp_valid), 48'd0);
      drain();

      // Overflow and truncation, back to back.
      set_op(0, 24'h001000, 24'h001000);
      step();
      set_op(0, 24'hFFFFFF, 24'hFFFFFF);
      step();
      chk("ovf1_prod", 48'(resp_prod), 48'h000000);
      chk("ovf1_flag", 48'(resp_ovf), 48'd1);
      set_op(0, 24'h000FFF, 24'h000FFF);
      step();
      chk("ovf2_prod", 48'(resp_prod), 48'h000001);
      chk("ovf2_flag", 48'(resp_ovf), 48'd1);
      req_valid = '0;
      step();
      chk("ovf3_prod", 48'(resp_prod), 48'hFFE001);
      chk("ovf3_flag", 48'(resp_ovf), 48'd0);
      drain();

      // Reset while both stages hold ops.
      resp_ready = '0;
      set_op(0, rnd24(), rnd24());
      set_op(1, rnd24(), rnd24());
      set_op(2, rnd24(), rnd24());
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req_ready", 48'(req_ready), 48'd0);
      chk("arst_resp_valid", 48'(resp_valid), 48'd0);
      chk("arst_resp_prod", 48'(resp_prod), 48'd0);
      chk("arst_resp_ovf", 48'(resp_ovf), 48'd0);
      step();
      req_valid  = 3'b110;
      resp_ready = '1;
      step();
      rst_n = 1'b1;
      #1 chk("arst_first_grant", 48'(req_ready), 48'b010);
      step();
      chk("arst_no_stale", 48'(resp_valid), 48'd0);
      req_valid = '0;
      drain();

      // Randomized traffic with varying backpressure.
      rdy_pct = 100;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rdy_pct = 100;
               1:       rdy_pct = 70;
               default: rdy_pct = 30;
            endcase
         end
         for (int i = 0; i < N; i++) begin
            resp_ready[i] = ($urandom_range(0, 99) < rdy_pct);
         end
         step();
         for (int i = 0; i < N; i++) begin
            if (m_grant[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < 70);
               req_a[i*W +: W] = rnd24();
               req_b[i*W +: W] = rnd24();
            end else if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
               set_op(i, rnd24(), rnd24());
            end
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
